// File: rtl/collision_scheduler.sv
// collision_scheduler: once per frame, walks every object pair through one shared
// AABB comparator (one pair per clock, three phases) and emits kill strobes and alive masks.
module collision_scheduler #(
    parameter int unsigned MAX_ENEMY         = 15,
    parameter int unsigned MAX_ENEMY_BULLET  = 31,
    parameter int unsigned MAX_PLAYER_BULLET = 15,
    parameter int unsigned ENEMY_WIDTH       = 36,
    parameter int unsigned ENEMY_HEIGHT      = 24,
    parameter int unsigned PLAYER_WIDTH      = 24,
    parameter int unsigned PLAYER_HEIGHT     = 36,
    parameter int unsigned BULLET_WIDTH      = 4,
    parameter int unsigned BULLET_HEIGHT     = 16,
    parameter logic [8:0]  PLAYER_Y          = 9'd420
) (
    input  logic                         i_Clk,
    input  logic                         i_Reset,
    input  logic                         i_Start,
    input  logic [MAX_ENEMY-1:0]         i_EnemyState,
    input  logic [MAX_ENEMY_BULLET-1:0]  i_EnemyBulletState,
    input  logic [MAX_PLAYER_BULLET-1:0] i_PlayerBulletState,
    input  logic                         i_PlayerState,
    input  logic [9:0]                   i_PlayerPosition,
    output logic [1:0]                   o_RdSelA,
    output logic [4:0]                   o_RdIdxA,
    output logic [1:0]                   o_RdSelB,
    output logic [4:0]                   o_RdIdxB,
    input  logic [18:0]                  i_RdPosA,
    input  logic [18:0]                  i_RdPosB,
    output logic                         o_KillValid,
    output logic [1:0]                   o_KillSelA,
    output logic [4:0]                   o_KillIdxA,
    output logic [1:0]                   o_KillSelB,
    output logic [4:0]                   o_KillIdxB,
    output logic                         o_PlayerHit,
    output logic                         o_Busy,
    output logic                         o_Done,
    output logic [MAX_ENEMY-1:0]         o_EnemyState,
    output logic [MAX_ENEMY_BULLET-1:0]  o_EnemyBulletState,
    output logic [MAX_PLAYER_BULLET-1:0] o_PlayerBulletState,
    output logic                         o_PlayerState
);

    localparam logic [1:0] SEL_ENEMY   = 2'd0;
    localparam logic [1:0] SEL_EBULLET = 2'd1;
    localparam logic [1:0] SEL_PBULLET = 2'd2;
    localparam logic [1:0] SEL_PLAYER  = 2'd3;

    localparam logic [4:0] LAST_E  = 5'(MAX_ENEMY - 1);
    localparam logic [4:0] LAST_EB = 5'(MAX_ENEMY_BULLET - 1);
    localparam logic [4:0] LAST_PB = 5'(MAX_PLAYER_BULLET - 1);

    typedef enum logic [2:0] {IDLE, SNAP, PH0, PH1, PH2, DONE} state_t;

    state_t     state;
    logic [4:0] cnt_i;
    logic [4:0] cnt_j;
    logic [9:0] player_x;

    logic       issue;
    logic [1:0] sel_a;
    logic [4:0] idx_a;
    logic [1:0] sel_b;
    logic [4:0] idx_b;

    logic       cmp_valid;
    logic [1:0] cmp_sel_a;
    logic [4:0] cmp_idx_a;
    logic [1:0] cmp_sel_b;
    logic [4:0] cmp_idx_b;

    logic [31:0] e_pad;
    logic [31:0] eb_pad;
    logic [31:0] pb_pad;

    logic [9:0]  a_x;
    logic [8:0]  a_y;
    logic [10:0] a_w;
    logic [9:0]  a_h;
    logic        a_alive;
    logic [9:0]  b_x;
    logic [8:0]  b_y;
    logic        b_alive;
    logic        ovl_x;
    logic        ovl_y;
    logic        hit;
    logic [31:0] clr_a;
    logic [31:0] clr_b;

    assign e_pad  = 32'(o_EnemyState);
    assign eb_pad = 32'(o_EnemyBulletState);
    assign pb_pad = 32'(o_PlayerBulletState);

    // Issue stage: pair addresses decode straight from the phase counters.
    always_comb begin
        issue = 1'b0;
        sel_a = '0;
        idx_a = '0;
        sel_b = '0;
        idx_b = '0;
        case (state)
            PH0: begin
                issue = 1'b1;
                sel_a = SEL_EBULLET;
                idx_a = cnt_i;
                sel_b = SEL_PBULLET;
                idx_b = cnt_j;
            end
            PH1: begin
                issue = 1'b1;
                sel_a = SEL_ENEMY;
                idx_a = cnt_i;
                sel_b = SEL_PBULLET;
                idx_b = cnt_j;
            end
            PH2: begin
                issue = 1'b1;
                sel_a = SEL_PLAYER;
                sel_b = SEL_EBULLET;
                idx_b = cnt_j;
            end
            default: ;
        endcase
    end

    assign o_RdSelA = sel_a;
    assign o_RdIdxA = idx_a;
    assign o_RdSelB = sel_b;
    assign o_RdIdxB = idx_b;

    // Compare stage: liveness is taken from the working masks as they are now.
    always_comb begin
        a_x     = i_RdPosA[18:9];
        a_y     = i_RdPosA[8:0];
        a_w     = 11'(BULLET_WIDTH);
        a_h     = 10'(BULLET_HEIGHT);
        a_alive = eb_pad[cmp_idx_a];
        case (cmp_sel_a)
            SEL_ENEMY: begin
                a_w     = 11'(ENEMY_WIDTH);
                a_h     = 10'(ENEMY_HEIGHT);
                a_alive = e_pad[cmp_idx_a];
            end
            SEL_PLAYER: begin
                a_x     = player_x;
                a_y     = PLAYER_Y;
                a_w     = 11'(PLAYER_WIDTH);
                a_h     = 10'(PLAYER_HEIGHT);
                a_alive = o_PlayerState;
            end
            default: ;
        endcase
        b_x     = i_RdPosB[18:9];
        b_y     = i_RdPosB[8:0];
        b_alive = (cmp_sel_b == SEL_EBULLET) ? eb_pad[cmp_idx_b] : pb_pad[cmp_idx_b];
        ovl_x   = ({1'b0, a_x} <= {1'b0, b_x} + 11'(BULLET_WIDTH)) &&
                  ({1'b0, b_x} <= {1'b0, a_x} + a_w);
        ovl_y   = ({1'b0, a_y} <= {1'b0, b_y} + 10'(BULLET_HEIGHT)) &&
                  ({1'b0, b_y} <= {1'b0, a_y} + a_h);
        hit     = cmp_valid && a_alive && b_alive && ovl_x && ovl_y;
        clr_a   = 32'd1 << cmp_idx_a;
        clr_b   = 32'd1 << cmp_idx_b;
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state               <= IDLE;
            cnt_i               <= '0;
            cnt_j               <= '0;
            player_x            <= '0;
            cmp_valid           <= 1'b0;
            cmp_sel_a           <= '0;
            cmp_idx_a           <= '0;
            cmp_sel_b           <= '0;
            cmp_idx_b           <= '0;
            o_KillValid         <= 1'b0;
            o_KillSelA          <= '0;
            o_KillIdxA          <= '0;
            o_KillSelB          <= '0;
            o_KillIdxB          <= '0;
            o_PlayerHit         <= 1'b0;
            o_Busy              <= 1'b0;
            o_Done              <= 1'b0;
            o_EnemyState        <= '0;
            o_EnemyBulletState  <= '0;
            o_PlayerBulletState <= '0;
            o_PlayerState       <= 1'b0;
        end else begin
            o_Done      <= 1'b0;
            o_KillValid <= 1'b0;
            o_PlayerHit <= 1'b0;
            cmp_valid   <= issue;
            cmp_sel_a   <= sel_a;
            cmp_idx_a   <= idx_a;
            cmp_sel_b   <= sel_b;
            cmp_idx_b   <= idx_b;

            case (state)
                IDLE: begin
                    if (i_Start) begin
                        state  <= SNAP;
                        o_Busy <= 1'b1;
                    end
                end
                SNAP: begin
                    o_EnemyState        <= i_EnemyState;
                    o_EnemyBulletState  <= i_EnemyBulletState;
                    o_PlayerBulletState <= i_PlayerBulletState;
                    o_PlayerState       <= i_PlayerState;
                    player_x            <= i_PlayerPosition;
                    cnt_i               <= '0;
                    cnt_j               <= '0;
                    state               <= PH0;
                end
                PH0: begin
                    if (cnt_j == LAST_PB) begin
                        cnt_j <= '0;
                        if (cnt_i == LAST_EB) begin
                            cnt_i <= '0;
                            state <= PH1;
                        end else begin
                            cnt_i <= cnt_i + 5'd1;
                        end
                    end else begin
                        cnt_j <= cnt_j + 5'd1;
                    end
                end
                PH1: begin
                    if (cnt_j == LAST_PB) begin
                        cnt_j <= '0;
                        if (cnt_i == LAST_E) begin
                            cnt_i <= '0;
                            state <= PH2;
                        end else begin
                            cnt_i <= cnt_i + 5'd1;
                        end
                    end else begin
                        cnt_j <= cnt_j + 5'd1;
                    end
                end
                PH2: begin
                    if (cnt_j == LAST_EB) begin
                        cnt_j <= '0;
                        state <= DONE;
                    end else begin
                        cnt_j <= cnt_j + 5'd1;
                    end
                end
                DONE: begin
                    o_Done <= 1'b1;
                    o_Busy <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // The last pair is still being compared while in DONE.
            if (hit) begin
                o_KillValid <= 1'b1;
                o_KillSelA  <= cmp_sel_a;
                o_KillIdxA  <= cmp_idx_a;
                o_KillSelB  <= cmp_sel_b;
                o_KillIdxB  <= cmp_idx_b;
                o_PlayerHit <= (cmp_sel_a == SEL_PLAYER);
                case (cmp_sel_a)
                    SEL_ENEMY:   o_EnemyState <= o_EnemyState & ~clr_a[MAX_ENEMY-1:0];
                    SEL_EBULLET: o_EnemyBulletState <= o_EnemyBulletState & ~clr_a[MAX_ENEMY_BULLET-1:0];
                    SEL_PLAYER:  o_PlayerState <= 1'b0;
                    default: ;
                endcase
                if (cmp_sel_b == SEL_EBULLET)
                    o_EnemyBulletState <= o_EnemyBulletState & ~clr_b[MAX_ENEMY_BULLET-1:0];
                else
                    o_PlayerBulletState <= o_PlayerBulletState & ~clr_b[MAX_PLAYER_BULLET-1:0];
            end
        end
    end

endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Sequential replacement for the all-pairs combinational collision check: once per frame it walks every object pair through a single shared AABB comparator, one pair per clock, over three fixed phases. It sits between the object tables (enemy, enemy bullet, player bullet) and the game-state update logic. It reads positions through two indexed read ports and emits kill strobes plus final alive masks.

## Interface
- MAX_ENEMY, 15, enemy slots
- MAX_ENEMY_BULLET, 31, enemy-bullet slots
- MAX_PLAYER_BULLET, 15, player-bullet slots
- ENEMY_WIDTH / ENEMY_HEIGHT, 36 / 24, enemy box size
- PLAYER_WIDTH / PLAYER_HEIGHT, 24 / 36, player box size
- BULLET_WIDTH / BULLET_HEIGHT, 4 / 16, box size for both bullet kinds
- PLAYER_Y, 9'd420, fixed player top edge
- i_Clk  in  1  clock; single clock domain
- i_Reset  in  1  synchronous, active-high reset
- i_Start  in  1  frame pulse; starts a pass when idle
- i_EnemyState  in  MAX_ENEMY  alive mask
- i_EnemyBulletState  in  MAX_ENEMY_BULLET  alive mask
- i_PlayerBulletState  in  MAX_PLAYER_BULLET  alive mask
- i_PlayerState  in  1  player alive
- i_PlayerPosition  in  10  player X
- o_RdSelA / o_RdSelB  out  2 each  table select: 0 enemy, 1 enemy bullet, 2 player bullet
- o_RdIdxA / o_RdIdxB  out  5 each  slot index
- i_RdPosA / i_RdPosB  in  19 each  {X[18:9], Y[8:0]}; valid one cycle after the index
- o_KillValid  out  1  kill strobe
- o_KillSelA, o_KillIdxA, o_KillSelB, o_KillIdxB  out  2/5/2/5  the two objects removed
- o_PlayerHit  out  1  player-hit strobe; accompanies o_KillValid in phase 2
- o_Busy  out  1  pass in progress
- o_Done  out  1  one-cycle end-of-pass pulse
- o_EnemyState, o_EnemyBulletState, o_PlayerBulletState, o_PlayerState  out  mask widths  working alive masks; final when o_Done is high

## Operation
- FSM states: IDLE, SNAP, PH0, PH1, PH2, DONE.
- IDLE: i_Start=1 moves to SNAP. i_Start is ignored in every other state.
- SNAP: latches the four masks and the player X into working registers. o_Busy rises.
- PH0: enemy bullet i (port A) vs player bullet j (port B). i is the outer loop, 0..MAX_ENEMY_BULLET-1; j is the inner loop.
- PH1: enemy i (A) vs player bullet j (B).
- PH2: player (A index unused; uses latched X and PLAYER_Y) vs enemy bullet j (B).
- Exactly one pair is issued per cycle, including dead pairs. Phases run back to back with no gap.
- Two-stage pipeline: issue, then compare. The compare stage gates on the working masks as they stand at compare time, so a kill made in cycle k suppresses that object in every comparison from k+1 on.
- Overlap, inclusive on both axes:
  - X: ax ≤ bx+bw and bx ≤ ax+aw, computed at 11 bits.
  - Y: same form, computed at 10 bits, with zero extension (no wrap).
- Hit in PH0 or PH1:
  - clear both working bits;
  - registered strobe next cycle: o_KillValid=1 with both sel/idx.
- Hit in PH2 with player alive:
  - clear the player bit and the bullet bit;
  - o_KillValid=1 and o_PlayerHit=1, KillSelA=3.
  - Once the player is dead, later bullets are not compared.
- DONE: o_Done=1 for one cycle, o_Busy=0, then IDLE.
- Output masks hold their value until the next SNAP.

## Timing
- Reset values: state IDLE; o_Busy, o_Done, o_KillValid, o_PlayerHit at 0; all masks 0; all sel/idx outputs 0.
- i_Start is sampled high in cycle 0. SNAP is cycle 1. Issue runs from cycle 2.
- Pair count N = EB·PB + E·PB + EB, which is 721 with default parameters.
- The last compare is at cycle N+2. o_Done and the last possible kill strobe both occur at cycle N+3 (724 by default).
- There is at most one kill per cycle. Kill strobes are registered.
- Reset at any cycle aborts the pass on the next edge. No strobes are emitted after reset.
- Input masks or positions that change mid-pass are not re-snapshotted. Only read data is live.

## Test plan
- Reset mid-pass at cycle 300 → next cycle: o_Busy=0, masks=0, no o_Done; a fresh i_Start then completes at +724.
- Single PH0 hit: EB[3] at (100,100), PB[7] at (102,110), all others dead → one strobe {1,3,2,7}; final EB[3]=0, PB[7]=0; o_Done at cycle 724.
- Edge touch: enemy at (200,50), PB at (236,74) → hit; PB at (237,74) → no hit.
- Shared bullet: PB[0] overlaps both EB[0] (PH0) and enemy[0] (PH1) → only the PH0 kill occurs; enemy[0] survives.
- Two enemy bullets overlap the player (X=300, Y=420) → exactly one o_PlayerHit, on the lower index; the other bullet stays alive.
- i_Start pulsed during a pass → ignored; exactly one o_Done.
